// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding, port ids and defaults for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEFAULT_MAX_WAIT = 15;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - winner selection between two requesters (round-robin when DMEM_ARB_RR_EN is defined)
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic grant_fire,
`endif
  input  logic p0_req,
  input  logic p1_req,
  output logic any_req,
  output logic winner
);

  assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_RR_EN
  logic ptr;

  // pointer moves to the port that did not win, so a contended pair alternates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PORT0;
    end else if (grant_fire) begin
      ptr <= ~winner;
    end
  end

  // on contention the pointer's port wins; otherwise the lone requester wins
  always_comb begin
    winner = PORT0;
    if (p0_req && p1_req) begin
      winner = ptr;
    end else if (p1_req) begin
      winner = PORT1;
    end
  end
`else
  // fixed priority: port 1 wins only when port 0 is not asking
  always_comb begin
    winner = PORT0;
    if (!p0_req && p1_req) begin
      winner = PORT1;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter/sequencer; optional round-robin via DMEM_ARB_RR_EN
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_we,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_readdata_valid,
  input  logic          mem_waitrequest,
  output logic          busy,
  output logic          grant_id
);

  state_t        state, state_n;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          grant_q;
  logic          err_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [7:0]    wait_cnt;

  logic          any_req;
  logic          winner;
  logic          rd_done;
  logic          timeout;
  logic          cap_en;
  logic [DW-1:0] cap_val;

  dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
    .grant_fire (state == IDLE && any_req),
`endif
    .p0_req     (p0_req),
    .p1_req     (p1_req),
    .any_req    (any_req),
    .winner     (winner)
  );

  assign rd_done = mem_readdata_valid && !mem_waitrequest;
  assign timeout = (wait_cnt >= 8'(MAX_WAIT));

  // next-state and memory strobes; timeout wins over a late valid because ren is already dropped
  always_comb begin
    state_n = state;
    mem_we  = 1'b0;
    mem_ren = 1'b0;
    cap_en  = 1'b0;
    cap_val = '0;
    case (state)
      IDLE: begin
        if (any_req) state_n = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          mem_we  = 1'b1;
          cap_en  = 1'b1;
          state_n = RESP;
        end else if (timeout) begin
          cap_en  = 1'b1;
          state_n = RESP;
        end else begin
          mem_ren = 1'b1;
          if (rd_done) begin
            cap_en  = 1'b1;
            cap_val = mem_rdata;
            state_n = RESP;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // latch the winner's request in IDLE, count read wait cycles, capture completion data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= PORT0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        we_q     <= (winner == PORT1) ? p1_we    : p0_we;
        addr_q   <= (winner == PORT1) ? p1_addr  : p0_addr;
        wdata_q  <= (winner == PORT1) ? p1_wdata : p0_wdata;
        grant_q  <= winner;
        err_q    <= 1'b0;
        wait_cnt <= '0;
      end else if (state == ACCESS && !cap_en && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == ACCESS && !we_q && timeout) begin
        err_q <= 1'b1;
      end
      if (cap_en) begin
        if (grant_q == PORT1) rdata1_q <= cap_val;
        else                  rdata0_q <= cap_val;
      end
    end
  end

  assign p0_ack    = (state == RESP) && (grant_q == PORT0);
  assign p1_ack    = (state == RESP) && (grant_q == PORT1);
  assign p0_err    = p0_ack && err_q;
  assign p1_err    = p1_ack && err_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with randomized traffic and a memory responder
module tb_dmem_arbiter;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we, mem_ren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_readdata_valid = 0, mem_waitrequest = 0;
  logic        busy, grant_id;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        expq0[$], expq1[$];
  int          latq0[$], latq1[$];
  logic [31:0] mem_model [0:15];
  logic [31:0] ref_mem   [0:15];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_addr[5:2]];

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_readdata_valid(mem_readdata_valid),
    .mem_waitrequest(mem_waitrequest),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end
  endtask

  // issue one transaction, push its expected completion, wait (bounded) for the ack
  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input int lat, input bit drop,
                       input int exp_lat);
    exp_t e;
    int   n;
    bit   got;
    int   idx;
    idx = int'(addr[5:2]);
    if (we) begin
      e.rdata = 32'h0;
      e.err   = 1'b0;
      ref_mem[idx] = wd;
    end else begin
      e.rdata = (lat < MW) ? ref_mem[idx] : 32'h0;
      e.err   = (lat >= MW);
      if (p == 0) latq0.push_back(lat);
      else        latq1.push_back(lat);
    end
    if (p == 0) expq0.push_back(e);
    else        expq1.push_back(e);
    @(posedge clk);
    #1;
    drive(p, 1'b1, we, addr, wd);
    n   = 0;
    got = 0;
    while (n < 300) begin
      @(negedge clk);
      if ((p == 0) ? p0_ack : p1_ack) begin
        got = 1;
        break;
      end
      n++;
      if (drop && n == 2) begin
        if (p == 0) p0_req = 1'b0;
        else        p1_req = 1'b0;
      end
    end
    if (!got) begin
      check($sformatf("ack_timeout_p%0d", p), 32'd0, 32'd1);
    end else if (exp_lat >= 0) begin
      check($sformatf("ack_latency_p%0d", p), n, exp_lat);
    end
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // memory side: writes land on the model, reads return valid after a per-request latency
  initial begin : responder
    bit active = 0;
    int cnt = 0;
    int lat = 0;
    forever begin
      @(negedge clk);
      if (mem_we) mem_model[mem_addr[5:2]] = mem_wdata;
      if (mem_ren) begin
        if (!active) begin
          active = 1;
          cnt    = 0;
          if (mem_addr[5]) lat = (latq1.size() > 0) ? latq1.pop_front() : 0;
          else             lat = (latq0.size() > 0) ? latq0.pop_front() : 0;
        end else begin
          cnt++;
        end
        if (cnt == lat) begin
          mem_readdata_valid = 1'b1;
          mem_waitrequest    = 1'b0;
        end else begin
          mem_waitrequest    = $urandom_range(0, 1) != 0;
          mem_readdata_valid = mem_waitrequest ? ($urandom_range(0, 1) != 0) : 1'b0;
        end
      end else begin
        active = 0;
        mem_readdata_valid = $urandom_range(0, 1) != 0;
        mem_waitrequest    = $urandom_range(0, 1) != 0;
      end
    end
  end

  // scoreboard monitor and per-cycle invariants
  initial begin : monitor
    int   we_run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we && mem_ren) check("we_ren_overlap", 32'd1, 32'd0);
        if (p0_ack && p1_ack)  check("double_ack", 32'd1, 32'd0);
        if (mem_we) begin
          we_run++;
        end else if (we_run > 0) begin
          check("mem_we_pulse_len", we_run, 1);
          we_run = 0;
        end
        if (p0_ack) begin
          if (expq0.size() == 0) check("unexpected_p0_ack", 32'd1, 32'd0);
          else begin
            e = expq0.pop_front();
            check("p0_rdata", p0_rdata, e.rdata);
            check("p0_err", {31'd0, p0_err}, {31'd0, e.err});
          end
        end
        if (p1_ack) begin
          if (expq1.size() == 0) check("unexpected_p1_ack", 32'd1, 32'd0);
          else begin
            e = expq1.pop_front();
            check("p1_rdata", p1_rdata, e.rdata);
            check("p1_err", {31'd0, p1_err}, {31'd0, e.err});
          end
        end
      end else begin
        we_run = 0;
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 16; i++) begin
      mem_model[i] = 32'hA5A50000 | i;
      ref_mem[i]   = 32'hA5A50000 | i;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_grant", {31'd0, grant_id}, 32'd0);
    check("reset_strobes", {30'd0, mem_we, mem_ren}, 32'd0);
    check("reset_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    check("reset_p0_rdata", p0_rdata, 32'd0);
    check("reset_p1_rdata", p1_rdata, 32'd0);

    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 2);
    issue(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 2);

    // simultaneous reads: loser is granted in the IDLE after the winner's ack
    fork
`ifdef DMEM_ARB_RR_EN
      issue(0, 1'b0, 32'h08, 32'h0, 0, 1'b0, 5);
      issue(1, 1'b0, 32'h28, 32'h0, 0, 1'b0, 2);
`else
      issue(0, 1'b0, 32'h08, 32'h0, 0, 1'b0, 2);
      issue(1, 1'b0, 32'h28, 32'h0, 0, 1'b0, 5);
`endif
    join

    issue(1, 1'b0, 32'h30, 32'h0, 20, 1'b0, MW + 2);
    issue(0, 1'b0, 32'h10, 32'h0, 3, 1'b1, 5);

    // reset in the ACCESS cycle of a port-1 write
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1, 32'h24, 32'h12345678);
    @(posedge clk);
    #3;
    check("pre_reset_mem_we", {31'd0, mem_we}, 32'd1);
    check("pre_reset_grant", {31'd0, grant_id}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_grant", {31'd0, grant_id}, 32'd0);
    check("async_reset_p1_ack", {31'd0, p1_ack}, 32'd0);
    check("async_reset_p1_rdata", p1_rdata, 32'd0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(1, 1'b0, 32'h24, 32'h0, 1, 1'b0, 3);
    issue(1, 1'b1, 32'h24, 32'hCAFEF00D, 0, 1'b0, 2);
    issue(1, 1'b0, 32'h24, 32'h0, 0, 1'b0, 2);

    // randomized concurrent traffic on disjoint address ranges
    fork
      for (int k = 0; k < 30; k++) begin
        int idx0, lat0;
        idx0 = $urandom_range(0, 7);
        lat0 = ($urandom_range(0, 4) == 0) ? MW + $urandom_range(0, 2) : $urandom_range(0, 4);
        issue(0, $urandom_range(0, 1) != 0, 32'(idx0 * 4), $urandom, lat0, 1'b0, -1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      for (int k = 0; k < 30; k++) begin
        int idx1, lat1;
        idx1 = $urandom_range(8, 15);
        lat1 = ($urandom_range(0, 4) == 0) ? MW + $urandom_range(0, 2) : $urandom_range(0, 4);
        issue(1, $urandom_range(0, 1) != 0, 32'(idx1 * 4), $urandom, lat1, 1'b0, -1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    join

    repeat (5) @(negedge clk);
    check("p0_queue_drained", expq0.size(), 0);
    check("p1_queue_drained", expq1.size(), 0);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the shared word-addressed data memory. Port 0 is the pipeline load/store unit. Port 1 is the debug/DMA loader. The block selects one requester and drives the memory strobes for exactly one access cycle. It then returns registered read data with a single-cycle ack, and times out reads the memory never validates.

Parameters:
AW, 32, address width, passed through unchanged to memory
DW, 32, data width
MAX_WAIT, 15, maximum cycles a read may wait for mem_readdata_valid before error completion (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
p0_req  in  1  port 0 request; held until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  AW  port 0 byte address
p0_wdata  in  DW  port 0 write data
p0_ack  out  1  port 0 completion pulse
p0_rdata  out  DW  port 0 read data, valid with p0_ack
p0_err  out  1  port 0 timeout flag, valid with p0_ack
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err  same as port 0, for port 1
mem_we  out  1  memory write enable
mem_ren  out  1  memory read enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, combinational
mem_readdata_valid  in  1  memory read data valid
mem_waitrequest  in  1  memory stall; ignored on writes
busy  out  1  high in any state other than IDLE
grant_id  out  1  port currently owning memory

Behaviour:
- Reset values: state=IDLE; all acks, errs and mem strobes 0; rdata registers 0; grant_id=0; wait counter 0; round-robin pointer=0.
- States and transitions:
  - IDLE: on any pX_req, choose a winner and latch its we, addr and wdata into internal registers. Set grant_id, then go to ACCESS. Priority is fixed with port 0 first unless DMEM_ARB_RR_EN is defined.
  - ACCESS, write: drive mem_we=1 with the latched addr/wdata for exactly one cycle, then go to RESP.
  - ACCESS, read: hold mem_ren=1 and the latched addr. The cycle mem_readdata_valid=1 and mem_waitrequest=0, capture mem_rdata into the winner's rdata register, then go to RESP.
  - ACCESS, read timeout: if that cycle has not arrived after MAX_WAIT cycles in ACCESS, deassert mem_ren, set err, set rdata=0, then go to RESP. The wait counter is 8-bit and saturating, and clears on entry to ACCESS.
  - RESP: pulse pX_ack=1 for exactly one cycle on the granted port only, with pX_err and pX_rdata. Then return to IDLE.
- Timing: a write acks 2 cycles after the IDLE grant cycle; a read with immediate valid acks 2 cycles after it; at most one access is outstanding.
- Latching: requester inputs are sampled only in IDLE. Changes while granted are ignored. Dropping pX_req mid-transaction does not abort it; the ack is still issued.
- Simultaneous requests: only one is granted. The loser stays pending and is granted in the next IDLE.
- Write data on ack: pX_rdata is 0 on a write ack. The rdata registers hold their value between acks.
- mem_we and mem_ren are never high together, and both are 0 outside ACCESS.
- Reset asserted mid-transaction: immediate return to IDLE, strobes dropped, no ack issued.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit pointer flips to the non-granted port after each grant. On simultaneous requests the pointer's port wins.
- Undefined: fixed priority, port 0 always wins. Pointer logic is not built.

Decomposition:
- Shared package dmem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), port-ID constants, and default MAX_WAIT.
- One natural sub-module, dmem_arb_pick: combinational winner selection from the two reqs plus pointer. Under DMEM_ARB_RR_EN it contains the pointer register.

Test Plan:
- p0 write addr=0x10, wdata=0xDEADBEEF, then p0 read 0x10 -> mem_we pulses for 1 cycle; read ack 2 cycles after grant with p0_rdata=0xDEADBEEF, p0_err=0.
- p0 and p1 both read in the same cycle, fixed priority -> p0 acked first, p1 granted in the next IDLE. With DMEM_ARB_RR_EN and both requesting continuously -> grants alternate 0,1,0,1.
- p1 read with mem_readdata_valid tied 0 for 20 cycles -> p1_ack at cycle MAX_WAIT+1 in ACCESS with p1_err=1, p1_rdata=0; mem_ren drops.
- p0 drops p0_req one cycle after grant -> transaction still completes; exactly one p0_ack.
- rst asserted during ACCESS of a p1 write -> all outputs return to reset values asynchronously; no p1_ack; a fresh request after reset completes normally.
- Every cycle (assertion): mem_we and mem_ren never both 1; at most one of p0_ack and p1_ack high.
